seg_scan_driver: RTL and testbench

- Parametrised multiplexed 7-segment driver, the successor to the current 8-digit score display path.
- Contains an internal refresh prescaler, an N-digit scan, and frame-synchronous latching of digit data so a frame never mixes old and new values.
- Adds hex glyphs, decimal points, leading-zero blanking, a per-digit blank mask and 16-level PWM brightness.
- Sits between the score/BCD logic and the board anode/cathode pins; all outputs are registered and active-low.

---
 rtl/seg_pkg.sv | 55 +++++
 rtl/seg_glyph_decode.sv | 18 +
 rtl/seg_scan_driver.sv | 172 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Glyph constants and lookup for the multiplexed 7-segment
//               driver. Segments a..g map to bits 0..6, active-low.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int PWM_LEVELS = 16;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
        logic [6:0] g;
        g = SEG_OFF;
        case (nib)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = SEG_A;
            4'hB: g = SEG_B;
            4'hC: g = SEG_C;
            4'hD: g = SEG_D;
            4'hE: g = SEG_E;
            4'hF: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_glyph_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_glyph_decode
// Description : Nibble to active-low cathode pattern; dark forces all off.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dark,
    output logic [6:0] o_cat
);

    assign o_cat = i_dark ? SEG_OFF : seg_glyph(i_nibble);

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : N-digit multiplexed 7-segment driver with frame-synchronous
//               shadowing, leading-zero blanking and 16-level PWM.
//               Optional per-digit blinking when SEG_BLINK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 1024,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lzb_en,
    input  logic [3:0]              brightness,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [6:0]              CAT,
    output logic                    DP,
    output logic                    frame_done
);

    localparam int c_pw   = $clog2(REFRESH_DIV);
    localparam int c_iw   = $clog2(NUM_DIGITS);
    localparam int c_br_w = $clog2(PWM_LEVELS);
    localparam logic [c_pw-1:0] c_presc_max = c_pw'(REFRESH_DIV - 1);
    localparam logic [c_iw-1:0] c_idx_max   = c_iw'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 16 || REFRESH_DIV < 16 ||
        (REFRESH_DIV & (REFRESH_DIV - 1)) != 0 || BLINK_FRAMES < 1) begin : g_param_check
        $error("seg_scan_driver: parameter out of range");
    end

    logic [c_pw-1:0]         r_presc;
    logic [c_iw-1:0]         r_idx;
    logic                    r_first;
    logic [4*NUM_DIGITS-1:0] r_sh_digits;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank;
    logic                    r_sh_lzb;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_cat;
    logic                    r_dp;
    logic                    r_fd;

    logic                    w_tick;
    logic                    w_frame_end;
    logic                    w_latch;
    logic [NUM_DIGITS:1]     w_zero_from;
    logic [NUM_DIGITS-1:0]   w_lzb;
    logic [3:0]              w_nib;
    logic                    w_blink_dark;
    logic                    w_dark;
    logic                    w_dp_n;
    logic                    w_pwm_on;
    logic [NUM_DIGITS-1:0]   w_an;
    logic [6:0]              w_cat;

    assign w_tick      = (r_presc == c_presc_max);
    assign w_frame_end = w_tick & (r_idx == c_idx_max);
    // The first cycle out of reset loads a frame before any digit is lit.
    assign w_latch     = r_first | w_frame_end;

    // Digit k is a leading zero when it and every digit above it is zero.
    assign w_zero_from[NUM_DIGITS] = (r_sh_digits[4*NUM_DIGITS-1 -: 4] == 4'h0);
    assign w_lzb[0] = 1'b0;
    for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lzb
        assign w_zero_from[k] = (r_sh_digits[4*k +: 4] == 4'h0) & w_zero_from[k+1];
        assign w_lzb[k]       = r_sh_lzb & w_zero_from[k];
    end

`ifdef SEG_BLINK_EN
    localparam int c_bw = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_bw-1:0] c_blink_max = c_bw'(BLINK_FRAMES - 1);

    logic [NUM_DIGITS-1:0] r_sh_blink;
    logic [c_bw-1:0]       r_frame_cnt;
    logic                  r_blink_off;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_blink  <= '0;
            r_frame_cnt <= '0;
            r_blink_off <= 1'b0;
        end else begin
            if (w_latch)
                r_sh_blink <= blink_mask;
            if (w_frame_end) begin
                if (r_frame_cnt == c_blink_max) begin
                    r_frame_cnt <= '0;
                    r_blink_off <= ~r_blink_off;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign w_blink_dark = r_blink_off & r_sh_blink[r_idx];
`else
    assign w_blink_dark = 1'b0;
`endif

    assign w_nib  = r_sh_digits[{r_idx, 2'b00} +: 4];
    assign w_dark = r_sh_blank[r_idx] | w_lzb[r_idx] | w_blink_dark;
    // Leading-zero blanking leaves the decimal point alone.
    assign w_dp_n = ~r_sh_dp[r_idx] | r_sh_blank[r_idx] | w_blink_dark;

    assign w_pwm_on = (r_presc[c_pw-1 -: c_br_w] <= brightness) & ~w_tick;

    always_comb begin
        w_an = '1;
        if (w_pwm_on)
            w_an[r_idx] = 1'b0;
    end

    seg_glyph_decode u_glyph (
        .i_nibble (w_nib),
        .i_dark   (w_dark),
        .o_cat    (w_cat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc     <= '0;
            r_idx       <= '0;
            r_first     <= 1'b1;
            r_sh_digits <= '0;
            r_sh_dp     <= '0;
            r_sh_blank  <= '0;
            r_sh_lzb    <= 1'b0;
            r_an        <= '1;
            r_cat       <= SEG_OFF;
            r_dp        <= 1'b1;
            r_fd        <= 1'b0;
        end else begin
            r_fd <= w_latch;
            if (w_latch) begin
                r_sh_digits <= digits_in;
                r_sh_dp     <= dp_in;
                r_sh_blank  <= blank_in;
                r_sh_lzb    <= lzb_en;
            end
            if (r_first) begin
                r_first <= 1'b0;
            end else begin
                r_presc <= r_presc + 1'b1;
                if (w_tick)
                    r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
                r_an  <= w_an;
                r_cat <= w_cat;
                r_dp  <= w_dp_n;
            end
        end
    end

    assign AN         = r_an;
    assign CAT        = r_cat;
    assign DP         = r_dp;
    assign frame_done = r_fd;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Self-checking bench for seg_scan_driver (8 digits, div 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int ND = 8;
    localparam int RD = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] digits_in;
    logic [7:0]  dp_in;
    logic [7:0]  blank_in;
    logic        lzb_en;
    logic [3:0]  brightness;
    logic [7:0]  AN;
    logic [6:0]  CAT;
    logic        DP;
    logic        frame_done;
`ifdef SEG_BLINK_EN
    logic [7:0]  blink_mask = 8'h00;
`endif

    seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .lzb_en     (lzb_en),
        .brightness (brightness),
`ifdef SEG_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .AN         (AN),
        .CAT        (CAT),
        .DP         (DP),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
            4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
            8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
           12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    // Model: m_n counts scan cycles since the first frame latch; slot and
    // phase follow by division, the frame data is what was sampled at latch.
    logic [7:0]  e_an  = 8'hFF;
    logic [6:0]  e_cat = 7'h7F;
    logic        e_dp  = 1'b1;
    logic        e_fd  = 1'b0;
    int          m_n   = -1;
    int          m_d   = -1;
    int          m_ph  = -1;
    logic [31:0] s_dig;
    logic [7:0]  s_dp, s_blank;
    logic        s_lzb, m_dark;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_an = 8'hFF; e_cat = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
            m_n = -1; m_d = -1; m_ph = -1;
            s_dig = '0; s_dp = '0; s_blank = '0; s_lzb = 1'b0;
        end else if (m_n < 0) begin
            s_dig = digits_in; s_dp = dp_in; s_blank = blank_in; s_lzb = lzb_en;
            e_fd = 1'b1;
            m_n  = 0;
        end else begin
            m_ph   = m_n % RD;
            m_d    = (m_n / RD) % ND;
            m_dark = s_blank[m_d] || (s_lzb && m_d > 0 && (s_dig >> (4 * m_d)) == 0);
            e_cat  = m_dark ? 7'h7F : glyph(int'((s_dig >> (4 * m_d)) & 32'hF));
            e_dp   = (s_dp[m_d] && !s_blank[m_d]) ? 1'b0 : 1'b1;
            e_an   = 8'hFF;
            if (m_ph != RD - 1 && (m_ph * 16 / RD) <= int'(brightness))
                e_an[m_d] = 1'b0;
            e_fd = ((m_n % (RD * ND)) == RD * ND - 1);
            if (e_fd) begin
                s_dig = digits_in; s_dp = dp_in; s_blank = blank_in; s_lzb = lzb_en;
            end
            m_n++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_an", AN, e_an);
            check("model_cat", CAT, e_cat);
            check("model_dp", DP, e_dp);
            check("model_frame_done", frame_done, e_fd);
        end
    end

    task automatic goto(input int d, input int ph);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (m_d == d && m_ph == ph) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL goto timeout: slot %0d phase %0d not reached", d, ph);
    endtask

    task automatic count_low(input int d, output int cnt);
        goto(d, 0);
        cnt = 0;
        for (int i = 0; i < RD; i++) begin
            if (AN[d] == 1'b0) cnt++;
            @(negedge clk);
        end
    endtask

    int c;

    initial begin
        digits_in = 32'h1234_5678; dp_in = 8'h00; blank_in = 8'h00;
        lzb_en = 1'b0; brightness = 4'd15;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_an", AN, 8'hFF);
        check("reset_cat", CAT, 7'h7F);
        check("reset_dp", DP, 1'b1);
        check("reset_fd", frame_done, 1'b0);

        reset = 1'b0;
        @(negedge clk);
        check("first_fd", frame_done, 1'b1);
        check("first_an", AN, 8'hFF);
        goto(0, 0);  check("d0_an", AN, 8'hFE); check("d0_cat", CAT, 7'h00);
        goto(0, 15); check("gap_an", AN, 8'hFF);
        goto(1, 0);  check("d1_an", AN, 8'hFD); check("d1_cat", CAT, 7'h78);
        goto(7, 3);  check("d7_an", AN, 8'h7F); check("d7_cat", CAT, 7'h79);

        // frame sync
        digits_in = 32'h0000_0001;
        goto(0, 0);  check("sync_old", CAT, 7'h79);
        digits_in = 32'h0000_0002;
        goto(0, 9);  check("sync_hold", CAT, 7'h79);
        goto(0, 0);  check("sync_new", CAT, 7'h24);

        // leading-zero blanking
        lzb_en = 1'b1; digits_in = 32'h0000_0205;
        goto(0, 0);  check("lzb_d0", CAT, 7'h12);
        goto(1, 0);  check("lzb_d1", CAT, 7'h40);
        goto(2, 0);  check("lzb_d2", CAT, 7'h24);
        goto(3, 0);  check("lzb_d3", CAT, 7'h7F);
        goto(7, 0);  check("lzb_d7", CAT, 7'h7F); check("lzb_d7_an", AN, 8'h7F);
        digits_in = 32'h0;
        goto(0, 0);  check("zero_d0", CAT, 7'h40);
        goto(1, 0);  check("zero_d1", CAT, 7'h7F); check("zero_d1_an", AN, 8'hFD);

        // brightness
        lzb_en = 1'b0; digits_in = 32'h1234_5678; brightness = 4'd0;
        goto(0, 0);
        count_low(3, c); check("bright0_on", c, 1);
        goto(3, 5);  check("bright0_cat", CAT, 7'h12);
        brightness = 4'd7;
        count_low(5, c); check("bright7_on", c, 8);
        goto(5, 12); check("bright7_off", AN, 8'hFF); check("bright7_cat", CAT, 7'h30);
        brightness = 4'd15;

        // hex glyphs, decimal point and blank mask
        digits_in = 32'hABCD_EF00; dp_in = 8'h01; blank_in = 8'h80;
        goto(0, 0);  check("hex_d0", CAT, 7'h40); check("hex_d0_dp", DP, 1'b0);
        goto(1, 0);  check("hex_d1_dp", DP, 1'b1);
        goto(2, 0);  check("hex_d2", CAT, 7'h0E);
        goto(3, 0);  check("hex_d3", CAT, 7'h06);
        goto(4, 0);  check("hex_d4", CAT, 7'h21);
        goto(5, 0);  check("hex_d5", CAT, 7'h46);
        goto(6, 0);  check("hex_d6", CAT, 7'h03);
        goto(7, 0);  check("hex_d7", CAT, 7'h7F); check("hex_d7_an", AN, 8'h7F);

        // asynchronous reset mid-scan
        goto(4, 3);  check("pre_rst_an", AN, 8'hEF);
        #2 reset = 1'b1;
        #1;
        check("async_an", AN, 8'hFF);
        check("async_cat", CAT, 7'h7F);
        check("async_dp", DP, 1'b1);
        check("async_fd", frame_done, 1'b0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk); check("rst2_fd", frame_done, 1'b1);
        @(negedge clk); check("rst2_an", AN, 8'hFE);
        goto(2, 0);  check("rst2_d2", CAT, 7'h0E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
